// File: rtl/ft_cmd_scheduler.sv
// rtl/ft_cmd_scheduler.sv - FT245 command parser and transmit scheduler
//
// Turns host command bytes into register-bus accesses and arbitrates the
// single FT245 transmit path between register read responses and the
// 16-bit pixel stream. A pixel is never split; a pending response wins at
// each pixel boundary.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   ft_rx_data/valid/ready      host bytes in (valid is a one-cycle strobe)
//   ft_tx_data/valid/ready      bytes out to the host
//   pix_data/valid/ready        16-bit pixel stream in (MSB byte sent first)
//   reg_addr/wdata/we/re        register bus, one-cycle strobes
//   reg_rdata                   read data, valid the cycle after reg_re
//   cmd_err                     one-cycle pulse on bad opcode or timeout
module ft_cmd_scheduler #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ft_rx_data,
  input  logic        ft_rx_valid,
  output logic        ft_rx_ready,
  output logic [7:0]  ft_tx_data,
  output logic        ft_tx_valid,
  input  logic        ft_tx_ready,
  input  logic [15:0] pix_data,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we,
  output logic        reg_re,
  input  logic [7:0]  reg_rdata,
  output logic        cmd_err
);

  typedef enum logic [1:0] {P_OP, P_ADDR, P_DATA, P_RD_WAIT} p_state_t;
  typedef enum logic [2:0] {TX_IDLE, TX_PIX_HI, TX_PIX_LO, TX_RSP_ADDR, TX_RSP_DATA} tx_state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  p_state_t        p_state, p_next;
  tx_state_t       tx_state, tx_next;
  logic            is_rd, is_rd_next;
  logic [TO_W-1:0] to_cnt, to_next;
  logic [7:0]      addr_next, wdata_next;
  logic            we_next, re_next, err_next;
  logic            rsp_set, rsp_clr;
  logic            rsp_pending, rsp_pending_next;
  logic [7:0]      rsp_addr, rsp_data;
  logic [15:0]     pix_q;
  logic            pix_load;
  logic            pix_ready_next;
  logic            rx_fire, tx_fire;

  // Holding off the host during a read and while its response is unsent
  // keeps at most one response in flight, so a one-entry buffer suffices.
  assign ft_rx_ready = (p_state != P_RD_WAIT) && !rsp_pending;
  assign rx_fire     = ft_rx_valid && ft_rx_ready;
  assign ft_tx_valid = (tx_state != TX_IDLE);
  assign tx_fire     = ft_tx_valid && ft_tx_ready;

  // ---------------- command parser ----------------
  always_comb begin
    p_next     = p_state;
    is_rd_next = is_rd;
    to_next    = '0;
    addr_next  = reg_addr;
    wdata_next = reg_wdata;
    we_next    = 1'b0;
    re_next    = 1'b0;
    err_next   = 1'b0;
    rsp_set    = 1'b0;
    case (p_state)
      P_OP: begin
        if (rx_fire) begin
          if (ft_rx_data == 8'h57) begin
            p_next     = P_ADDR;
            is_rd_next = 1'b0;
          end else if (ft_rx_data == 8'h52) begin
            p_next     = P_ADDR;
            is_rd_next = 1'b1;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      P_ADDR: begin
        if (rx_fire) begin
          addr_next = ft_rx_data;
          if (is_rd) begin
            re_next = 1'b1;
            p_next  = P_RD_WAIT;
          end else begin
            p_next = P_DATA;
          end
        end else if (to_cnt == TO_LAST) begin
          err_next = 1'b1;
          p_next   = P_OP;
        end else begin
          to_next = to_cnt + TO_W'(1);
        end
      end
      P_DATA: begin
        if (rx_fire) begin
          wdata_next = ft_rx_data;
          we_next    = 1'b1;
          p_next     = P_OP;
        end else if (to_cnt == TO_LAST) begin
          err_next = 1'b1;
          p_next   = P_OP;
        end else begin
          to_next = to_cnt + TO_W'(1);
        end
      end
      P_RD_WAIT: begin
        // reg_re is high during the first cycle here; read data arrives
        // the cycle after, i.e. once reg_re has dropped.
        if (!reg_re) begin
          rsp_set = 1'b1;
          p_next  = P_OP;
        end
      end
      default: p_next = P_OP;
    endcase
  end

  // ---------------- transmit scheduler ----------------
  always_comb begin
    tx_next  = tx_state;
    pix_load = 1'b0;
    rsp_clr  = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (rsp_pending) begin
          tx_next = TX_RSP_ADDR;
        end else if (pix_ready && pix_valid) begin
          pix_load = 1'b1;
          tx_next  = TX_PIX_HI;
        end
      end
      TX_PIX_HI:   if (tx_fire) tx_next = TX_PIX_LO;
      TX_PIX_LO:   if (tx_fire) tx_next = TX_IDLE;
      TX_RSP_ADDR: if (tx_fire) tx_next = TX_RSP_DATA;
      TX_RSP_DATA: begin
        if (tx_fire) begin
          rsp_clr = 1'b1;
          tx_next = TX_IDLE;
        end
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  // Set and clear never coincide: a response is only captured while none
  // is pending, and only cleared while one is.
  always_comb begin
    rsp_pending_next = rsp_pending;
    if (rsp_set)      rsp_pending_next = 1'b1;
    else if (rsp_clr) rsp_pending_next = 1'b0;
  end

  // Registered pix_ready: predict next cycle's idle-with-no-response state.
  assign pix_ready_next = (tx_next == TX_IDLE) && !rsp_pending_next;

  always_comb begin
    ft_tx_data = 8'h00;
    case (tx_state)
      TX_PIX_HI:   ft_tx_data = pix_q[15:8];
      TX_PIX_LO:   ft_tx_data = pix_q[7:0];
      TX_RSP_ADDR: ft_tx_data = rsp_addr;
      TX_RSP_DATA: ft_tx_data = rsp_data;
      default:     ft_tx_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_state     <= P_OP;
      tx_state    <= TX_IDLE;
      is_rd       <= 1'b0;
      to_cnt      <= '0;
      reg_addr    <= 8'h00;
      reg_wdata   <= 8'h00;
      reg_we      <= 1'b0;
      reg_re      <= 1'b0;
      cmd_err     <= 1'b0;
      rsp_pending <= 1'b0;
      rsp_addr    <= 8'h00;
      rsp_data    <= 8'h00;
      pix_q       <= 16'h0000;
      pix_ready   <= 1'b0;
    end else begin
      p_state     <= p_next;
      tx_state    <= tx_next;
      is_rd       <= is_rd_next;
      to_cnt      <= to_next;
      reg_addr    <= addr_next;
      reg_wdata   <= wdata_next;
      reg_we      <= we_next;
      reg_re      <= re_next;
      cmd_err     <= err_next;
      rsp_pending <= rsp_pending_next;
      pix_ready   <= pix_ready_next;
      if (rsp_set) begin
        rsp_addr <= reg_addr;
        rsp_data <= reg_rdata;
      end
      if (pix_load) pix_q <= pix_data;
    end
  end

endmodule

// File: tb/tb_ft_cmd_scheduler.sv
// tb/tb_ft_cmd_scheduler.sv - self-checking bench for ft_cmd_scheduler
module tb_ft_cmd_scheduler;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ft_rx_data = 8'h00;
  logic        ft_rx_valid = 1'b0;
  logic        ft_rx_ready;
  logic [7:0]  ft_tx_data;
  logic        ft_tx_valid;
  logic        ft_tx_ready = 1'b1;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [7:0]  reg_rdata = 8'h00;
  logic        cmd_err;

  always #5 clk = ~clk;

  ft_cmd_scheduler #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .ft_rx_data(ft_rx_data), .ft_rx_valid(ft_rx_valid), .ft_rx_ready(ft_rx_ready),
    .ft_tx_data(ft_tx_data), .ft_tx_valid(ft_tx_valid), .ft_tx_ready(ft_tx_ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .cmd_err(cmd_err)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Commands are parsed from the byte stream as whole messages; transmit
  // order is the order in which pixels and completed reads are presented.
  logic [7:0]  exp_tx[$];
  logic [15:0] exp_wr[$];
  logic [7:0]  exp_rd[$];
  logic [7:0]  cmd_buf[$];
  int          exp_err = 0;

  function automatic void model_rx(input logic [7:0] b);
    if (cmd_buf.size() == 0 && b != 8'h57 && b != 8'h52) begin
      exp_err++;
    end else begin
      cmd_buf.push_back(b);
      if (cmd_buf[0] == 8'h57 && cmd_buf.size() == 3) begin
        exp_wr.push_back({cmd_buf[1], cmd_buf[2]});
        cmd_buf.delete();
      end else if (cmd_buf[0] == 8'h52 && cmd_buf.size() == 2) begin
        exp_rd.push_back(cmd_buf[1]);
        exp_tx.push_back(cmd_buf[1]);
        exp_tx.push_back(reg_rdata);
        cmd_buf.delete();
      end
    end
  endfunction

  function automatic void model_pix(input logic [15:0] p);
    exp_tx.push_back(p[15:8]);
    exp_tx.push_back(p[7:0]);
  endfunction

  function automatic void model_timeout();
    cmd_buf.delete();
    exp_err++;
  endfunction

  function automatic void model_reset();
    cmd_buf.delete();
    exp_tx.delete();
  endfunction

  // ---------------- compare process ----------------
  logic [7:0] tx_log[$];
  int         act_we = 0, act_re = 0, act_err = 0, act_pix = 0;
  logic [7:0] last_addr = 8'h00, last_wdata = 8'h00;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("tx_hold_valid", ft_tx_valid, 1);
        chk("tx_hold_data", ft_tx_data, prev_data);
      end
      if (ft_tx_valid && ft_tx_ready) begin
        tx_log.push_back(ft_tx_data);
        if (exp_tx.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL tx_unexpected: got byte 0x%0h, expected no byte", ft_tx_data);
        end else begin
          chk("tx_byte", ft_tx_data, exp_tx.pop_front());
        end
      end
      if (reg_we) begin
        act_we++;
        last_addr  = reg_addr;
        last_wdata = reg_wdata;
        if (exp_wr.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL we_unexpected: got write 0x%0h=0x%0h, expected none", reg_addr, reg_wdata);
        end else begin
          chk("reg_write", {reg_addr, reg_wdata}, exp_wr.pop_front());
        end
      end
      if (reg_re) begin
        act_re++;
        if (exp_rd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL re_unexpected: got read 0x%0h, expected none", reg_addr);
        end else begin
          chk("reg_read", reg_addr, exp_rd.pop_front());
        end
      end
      if (cmd_err) act_err++;
      if (pix_valid && pix_ready) begin
        act_pix++;
        chk("pix_in_idle", ft_tx_valid, 0);
      end
      prev_hold = ft_tx_valid && !ft_tx_ready;
      prev_data = ft_tx_data;
    end
  end

  // ---------------- stimulus helpers (start and end at posedge+1) ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rx(input logic [7:0] b);
    int i;
    model_rx(b);
    for (i = 0; i < 200; i++) begin
      if (ft_rx_ready) break;
      step(1);
    end
    if (i == 200) begin
      n_chk++; n_fail++;
      $display("FAIL rx_ready_timeout: got ft_rx_ready=0 for 200 cycles, expected 1");
    end
    ft_rx_data  = b;
    ft_rx_valid = 1'b1;
    step(1);
    ft_rx_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [15:0] p);
    logic got;
    got = 1'b0;
    model_pix(p);
    pix_data  = p;
    pix_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (pix_ready) begin
        got = 1'b1;
        step(1);
        break;
      end
      step(1);
    end
    pix_valid = 1'b0;
    chk("pix_accepted", got, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_tx.size() == 0) break;
      step(1);
    end
    chk("tx_drained", exp_tx.size(), 0);
  endtask

  task automatic chk_log(input string name, input int n, input logic [47:0] bytes);
    logic [7:0] e;
    chk({name, "_len"}, tx_log.size(), n);
    for (int i = 0; i < n; i++) begin
      e = bytes[8*(n-1-i) +: 8];
      if (i < tx_log.size()) chk(name, tx_log[i], e);
    end
    tx_log.delete();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_tx_valid", ft_tx_valid, 0);
    chk("rst_tx_data", ft_tx_data, 8'h00);
    chk("rst_rx_ready", ft_rx_ready, 1);
    chk("rst_pix_ready", pix_ready, 0);
    chk("rst_reg_we", reg_we, 0);
    chk("rst_reg_re", reg_re, 0);
    chk("rst_reg_addr", reg_addr, 8'h00);
    chk("rst_reg_wdata", reg_wdata, 8'h00);
    chk("rst_cmd_err", cmd_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic got;
    #2;
    chk_reset_outputs();
    step(3);
    rst_n = 1'b1;
    step(2);

    // register write
    rx(8'h57); rx(8'h10); rx(8'hAB);
    step(3);
    chk("wr_count", act_we, 1);
    chk("wr_addr", last_addr, 8'h10);
    chk("wr_data", last_wdata, 8'hAB);
    chk("wr_no_tx", tx_log.size(), 0);

    // register read
    reg_rdata = 8'h5C;
    rx(8'h52); rx(8'h22);
    chk("rd_rx_ready_low", ft_rx_ready, 0);
    step(2);
    chk("rd_rx_ready_still_low", ft_rx_ready, 0);
    wait_drain();
    step(2);
    chk("rd_rx_ready_back", ft_rx_ready, 1);
    chk("rd_count", act_re, 1);
    chk_log("rd_seq", 2, 48'h225C);

    // back-to-back pixels
    act_pix = 0;
    send_pix(16'hF1E2);
    send_pix(16'hD3C4);
    wait_drain();
    step(2);
    chk("pix_count", act_pix, 2);
    chk_log("pix_seq", 4, 48'hF1E2D3C4);

    // response becomes pending while a pixel is stalled
    ft_tx_ready = 1'b0;
    reg_rdata   = 8'h77;
    send_pix(16'h1234);
    rx(8'h52); rx(8'h40);
    step(3);
    chk("prio_stalled_hi", ft_tx_data, 8'h12);
    model_pix(16'h5678);
    pix_data    = 16'h5678;
    pix_valid   = 1'b1;
    ft_tx_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (pix_ready) begin
        got = 1'b1;
        step(1);
        break;
      end
      step(1);
    end
    pix_valid = 1'b0;
    chk("prio_pix2_accepted", got, 1);
    wait_drain();
    step(2);
    chk_log("prio_seq", 6, 48'h123440775678);

    // bad opcode, timeout, then a good write
    rx(8'h00);
    step(2);
    chk("err_bad_op", act_err, exp_err);
    chk("err_bad_op_lit", act_err, 1);
    rx(8'h57); rx(8'h10);
    step(TO - 3);
    chk("err_not_early", act_err, 1);
    model_timeout();
    step(6);
    chk("err_timeout", act_err, exp_err);
    chk("err_timeout_lit", act_err, 2);
    chk("timeout_no_we", act_we, 1);
    rx(8'h57); rx(8'h11); rx(8'h01);
    step(3);
    chk("after_to_we", act_we, 2);
    chk("after_to_addr", last_addr, 8'h11);
    chk("after_to_data", last_wdata, 8'h01);

    // reset mid-pixel (low byte stalled) and mid-command (awaiting data)
    ft_tx_ready = 1'b0;
    rx(8'h57); rx(8'h33);
    send_pix(16'hABCD);
    ft_tx_ready = 1'b1;
    step(1);
    ft_tx_ready = 1'b0;
    step(1);
    chk("rst_lo_stalled", ft_tx_data, 8'hCD);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    tx_log.delete();
    step(2);
    rst_n = 1'b1;
    ft_tx_ready = 1'b1;
    step(1);
    send_pix(16'h9ABC);
    rx(8'h57); rx(8'h44); rx(8'h55);
    wait_drain();
    step(3);
    chk_log("post_rst_seq", 2, 48'h9ABC);
    chk("post_rst_we", act_we, 3);
    chk("post_rst_addr", last_addr, 8'h44);
    chk("post_rst_data", last_wdata, 8'h55);

    // nothing left outstanding
    chk("end_wr_queue", exp_wr.size(), 0);
    chk("end_rd_queue", exp_rd.size(), 0);
    chk("end_err", act_err, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ft_cmd_scheduler.md
Name: ft_cmd_scheduler

Overview:
- Sits between the sync_ft245 FIFO interface and the camera core.
- Parses host command bytes arriving from the FT245 into register-bus writes and reads.
- Schedules all bytes sent to the host, sharing the single FT245 transmit path between register read responses and the 16-bit CCD pixel stream.
- Pixels are never split by a response; a pending response has priority at each pixel boundary.

Parameters:
TIMEOUT_CYCLES, 1024, clk cycles a partially received command may sit idle before it is discarded (min 2).
TO_W, 11, timeout counter width; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  FT245 CLKOUT domain clock (60 MHz)
rst_n  in  1  asynchronous active-low reset
ft_rx_data  in  8  byte from sync_ft245 (data_from_ft)
ft_rx_valid  in  1  one-cycle strobe per received byte (data_from_ft_avail)
ft_rx_ready  out  1  scheduler can accept host bytes; sync_ft245 stops reading while low
ft_tx_data  out  8  byte to sync_ft245 (data_to_ft)
ft_tx_valid  out  1  byte offered (data_to_ft_avail)
ft_tx_ready  in  1  byte consumed when ft_tx_valid && ft_tx_ready
pix_data  in  16  pixel sample
pix_valid  in  1  pixel offered
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
reg_addr  out  8  register address
reg_wdata  out  8  register write data
reg_we  out  1  one-cycle write strobe
reg_re  out  1  one-cycle read strobe
reg_rdata  in  8  read data, valid the cycle after reg_re
cmd_err  out  1  one-cycle pulse on a bad opcode or a timeout

Behaviour:
Reset, asynchronous, all outputs: ft_tx_valid=0, ft_tx_data=0x00, ft_rx_ready=1, pix_ready=0, reg_we=0, reg_re=0, reg_addr=0x00, reg_wdata=0x00, cmd_err=0. Both FSMs go to their idle state, the response buffer empties and the timeout counter clears. Reset mid-command or mid-pixel drops the partial command or pixel silently.

Command parser FSM (P_OP, P_ADDR, P_DATA, P_RD_WAIT). Bytes are consumed only when ft_rx_valid && ft_rx_ready.
- P_OP, byte 0x57 ('W') -> P_ADDR, write flagged.
- P_OP, byte 0x52 ('R') -> P_ADDR, read flagged.
- P_OP, any other byte -> cmd_err pulses one cycle, stay in P_OP.
- P_ADDR -> latch reg_addr.
  - Write: -> P_DATA.
  - Read: reg_re=1 for the next cycle -> P_RD_WAIT.
- P_DATA -> latch reg_wdata, reg_we=1 for the next cycle -> P_OP.
- P_RD_WAIT: the cycle after reg_re, capture {reg_addr, reg_rdata} into the response buffer and set rsp_pending -> P_OP.
- ft_rx_ready = 0 while in P_RD_WAIT or while rsp_pending=1; this guarantees one outstanding read and no lost bytes.
- Timeout: the counter runs in P_ADDR and P_DATA and clears on every accepted byte. On reaching TIMEOUT_CYCLES-1 with no byte: cmd_err pulses, -> P_OP, no register strobe.

Transmit FSM (TX_IDLE, TX_PIX_HI, TX_PIX_LO, TX_RSP_ADDR, TX_RSP_DATA):
- TX_IDLE, rsp_pending=1 -> TX_RSP_ADDR. Response wins over a simultaneously valid pixel.
- TX_IDLE, otherwise: pix_ready=1; on pix_valid, latch the pixel -> TX_PIX_HI. ft_tx_valid rises the next cycle.
- pix_ready=1 only in TX_IDLE with rsp_pending=0; it is a registered output.
- TX_PIX_HI: ft_tx_data=pixel[15:8]; on handshake -> TX_PIX_LO.
- TX_PIX_LO: ft_tx_data=pixel[7:0]; on handshake -> TX_IDLE.
- TX_RSP_ADDR: ft_tx_data=addr; on handshake -> TX_RSP_DATA.
- TX_RSP_DATA: ft_tx_data=data; on handshake clear rsp_pending -> TX_IDLE.
- ft_tx_valid=1 in every state except TX_IDLE. ft_tx_data holds stable until the handshake.
- Back-to-back pixels cost one TX_IDLE cycle between them.
- A response arriving mid-pixel waits until TX_PIX_LO completes.
- ft_tx_ready low for any duration stalls the FSM with data held stable.

Test Plan:
- Write: rx 0x57,0x10,0xAB on consecutive cycles -> exactly one reg_we pulse with reg_addr=0x10, reg_wdata=0xAB; no tx bytes.
- Read: rx 0x52,0x22 with reg_rdata=0x5C -> one reg_re pulse; ft_rx_ready low until tx emits 0x22 then 0x5C; ft_rx_ready then returns to 1.
- Pixels with ft_tx_ready=1: pix_data 0xF1E2 then 0xD3C4 -> tx sequence F1,E2,D3,C4; pix_ready high exactly twice.
- Priority: read response becomes pending while TX_PIX_HI of 0x1234 is stalled by ft_tx_ready=0 -> tx 12,34,addr,data; the next queued pixel follows only after the response.
- Errors: rx 0x00 -> cmd_err pulse, parser stays in P_OP. Rx 0x57,0x10 then silence for TIMEOUT_CYCLES -> cmd_err pulse, no reg_we. A following 0x57,0x11,0x01 -> normal write.
- Reset: assert rst_n=0 during TX_PIX_LO and in P_DATA -> all outputs return to reset values immediately; after release the next pixel starts at its MSB.
